// File: rtl/mem_responder.sv
// Memory-side responder: clear sweep after reset, one-entry write buffer with read forwarding.
// Optional bus-select checker enabled by defining MEM_BUS_CHECK_EN.
module mem_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              resetMEM,
  input  logic [ADDR_W-1:0] AR,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              Memoryin,
  input  logic              Memoryout,
  input  logic              MemWrite,
  input  logic [5:0]        BUSld,
  output logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              cmd_err,
  output logic              bus_conflict
);

  typedef enum logic [1:0] {CLEAR, IDLE, COMMIT} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_v_q;
  logic              busy_q;
  logic              cmd_err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ar_ok;
  logic              wr_cmd;
  logic              wr_ok;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_wa_d;
  logic [DATA_W-1:0] mem_wd_d;

  assign ar_ok  = {1'b0, AR} < (ADDR_W+1)'(DEPTH);
  assign wr_cmd = Memoryin & MemWrite;
  // Out-of-range writes never occupy the buffer.
  assign wr_ok  = wr_cmd & ar_ok;

  always_ff @(posedge clk) begin
    if (resetMEM) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_v_q    <= 1'b0;
      busy_q    <= 1'b1;
      cmd_err_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (wr_cmd | Memoryout) cmd_err_q <= 1'b1;
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (wr_ok) begin
            wb_addr_q <= AR;
            wb_data_q <= bus_in;
            wb_v_q    <= 1'b1;
            state_q   <= COMMIT;
          end
        end
        COMMIT: begin
          if (wr_ok) begin
            wb_addr_q <= AR;
            wb_data_q <= bus_in;
          end else begin
            wb_v_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Single array write port shared by the sweep and the buffer commit.
  always_comb begin
    mem_we_d = 1'b0;
    mem_wa_d = cnt_q;
    mem_wd_d = '0;
    if (!resetMEM) begin
      if (state_q == CLEAR) begin
        mem_we_d = 1'b1;
      end else if (state_q == COMMIT) begin
        mem_we_d = 1'b1;
        mem_wa_d = wb_addr_q;
        mem_wd_d = wb_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[mem_wa_d] <= mem_wd_d;
  end

  always_comb begin
    mem_out = '0;
    if (state_q != CLEAR && Memoryout && ar_ok)
      mem_out = (wb_v_q && wb_addr_q == AR) ? wb_data_q : mem_q[AR];
  end

  assign busy    = busy_q;
  assign cmd_err = cmd_err_q;

`ifdef MEM_BUS_CHECK_EN
  logic bus_conflict_q;

  // More than one bit set: x & (x-1) is nonzero.
  always_ff @(posedge clk) begin
    if (resetMEM)
      bus_conflict_q <= 1'b0;
    else if (state_q != CLEAR && (BUSld & (BUSld - 6'd1)) != 6'd0)
      bus_conflict_q <= 1'b1;
  end

  assign bus_conflict = bus_conflict_q;
`else
  logic unused_busld;
  assign unused_busld = ^BUSld;
  assign bus_conflict = 1'b0;
`endif

endmodule
